// File: rtl/sevenseg_hex_display.sv
// Snapshots a 16-bit word at a slow rate and scans it as 4 hex digits on a common-anode display.
// All outputs registered (one cycle behind counters/snapshot); no backpressure, free-running scan.
module sevenseg_hex_display #(
  parameter int          REFRESH_DIV  = 100000,
  parameter int          BLANK_CYCLES = 16,
  parameter int          UPDATE_DIV   = 50000000,
  parameter int          BLANK_LZ     = 1,
  parameter logic [3:0]  DP_MASK      = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        snap_strobe
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int UW = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] BLANK_END    = RW'(BLANK_CYCLES);
  localparam logic [UW-1:0] UPDATE_LAST  = UW'(UPDATE_DIV - 1);

  typedef enum logic {PH_BLANK, PH_ON} phase_t;

  logic [RW-1:0] refresh_cnt;
  logic [UW-1:0] update_cnt;
  logic [1:0]    idx;
  logic [15:0]   snapshot;

  phase_t        phase;
  logic          refresh_wrap;
  logic          update_wrap;
  logic [3:0]    nibble;
  logic [15:0]   upper;
  logic          dark;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h7F;
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    phase        = (refresh_cnt < BLANK_END) ? PH_BLANK : PH_ON;
    refresh_wrap = (refresh_cnt == REFRESH_LAST);
    update_wrap  = (update_cnt == UPDATE_LAST);
    nibble       = snapshot[{idx, 2'b00} +: 4];
    // Digit 0 is never blanked so a zero value still shows a single '0'.
    upper        = snapshot >> {idx, 2'b00};
    dark         = (BLANK_LZ != 0) && (idx != 2'd0) && (upper == 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      update_cnt  <= '0;
      idx         <= 2'd0;
      snapshot    <= 16'h0000;
      an          <= 4'b1111;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      snap_strobe <= 1'b0;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
      if (refresh_wrap)
        idx <= idx + 2'd1;

      update_cnt  <= update_wrap ? '0 : update_cnt + 1'b1;
      snap_strobe <= 1'b0;
      if (update_wrap && !hold) begin
        snapshot    <= value;
        snap_strobe <= 1'b1;
      end

      if (phase == PH_ON && !dark) begin
        an  <= ~(4'b0001 << idx);
        seg <= hex7(nibble);
        dp  <= ~DP_MASK[idx];
      end else begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
